// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Owns the HI/LO register pair. Executes MULT/MULTU/DIV/DIVU iteratively
// (one bit per clock), MTHI/MTLO in a single cycle, and returns HI/LO for
// MFHI/MFLO.
//
// Optional macro: HILO_EARLY_OUT_EN
//   Defined   - a multiply stops once no set multiplier bits remain, and a
//               divide with a zero dividend skips straight to FIX.
//   Undefined - every multiply/divide takes ITER+1 Busy cycles.
//
// Ports:
//   CLK       system clock, rising edge
//   RST       asynchronous active-low reset
//   Valid     Ins is live this cycle
//   Op, Func  Ins[31:26], Ins[5:0]
//   Rdata1/2  rs / rt operands
//   Busy      multiply/divide in flight
//   Stall     hold PC/ID (combinational)
//   HiLoData  HI for MFHI, LO for MFLO, else 0
//   Hi, Lo    HI/LO registers (trace)
module hilo_muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Valid,
  input  logic [5:0]  Op,
  input  logic [5:0]  Func,
  input  logic [31:0] Rdata1,
  input  logic [31:0] Rdata2,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HiLoData,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam logic [5:0] R_FORM  = 6'h00;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int CW = $clog2(ITER + 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi, r_lo;
  // Multiply: r_acc = running product, r_a = shifted multiplicand,
  //           r_b = multiplier shifting right.
  // Divide:   r_acc = {remainder, dividend/quotient}, r_b = divisor.
  logic [63:0]   r_acc;
  logic [63:0]   r_a;
  logic [31:0]   r_b;
  logic          r_div, r_neg_q, r_neg_r, r_dz;
  logic [31:0]   r_dvd;

  logic        w_rform, w_hilo, w_md, w_signed, w_isdiv, w_go, w_early, w_last;
  logic [31:0] w_abs1, w_abs2;
  logic [63:0] w_mul_acc, w_div_acc;
  logic [33:0] w_diff;

  assign w_rform  = (Op == R_FORM);
  assign w_md     = w_rform && (Func == F_MULT || Func == F_MULTU ||
                                Func == F_DIV  || Func == F_DIVU);
  assign w_hilo   = w_md || (w_rform && (Func == F_MFHI || Func == F_MTHI ||
                                         Func == F_MFLO || Func == F_MTLO));
  assign w_signed = (Func == F_MULT) || (Func == F_DIV);
  assign w_isdiv  = (Func == F_DIV)  || (Func == F_DIVU);

  assign Busy  = (r_state != S_IDLE);
  assign Stall = Valid && Busy && w_hilo;
  // Commands only act while idle; a busy HI/LO command is stalled instead.
  assign w_go  = Valid && !Busy;

  assign w_abs1 = (w_signed && Rdata1[31]) ? (32'd0 - Rdata1) : Rdata1;
  assign w_abs2 = (w_signed && Rdata2[31]) ? (32'd0 - Rdata2) : Rdata2;

  // Shift-add multiply step.
  assign w_mul_acc = r_b[0] ? (r_acc + r_a) : r_acc;

  // Restoring divide step: trial-subtract divisor from {R, next dividend bit}.
  assign w_diff    = {1'b0, r_acc[63:32], r_acc[31]} - {2'b00, r_b};
  assign w_div_acc = w_diff[33] ? {r_acc[62:0], 1'b0}
                                : {w_diff[31:0], r_acc[30:0], 1'b1};

`ifdef HILO_EARLY_OUT_EN
  // Divide: an all-zero {R,Q} can only yield 0/0; divide-by-zero is
  // overridden in FIX anyway. Multiply: no multiplier bits left after this step.
  assign w_early = r_div ? (r_acc == 64'd0) : (r_b[31:1] == 31'd0);
`else
  assign w_early = 1'b0;
`endif

  assign w_last = (r_cnt == CW'(ITER - 1)) || w_early;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_dvd   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go && w_md) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_div   <= w_isdiv;
            r_acc   <= w_isdiv ? {32'd0, w_abs1} : 64'd0;
            r_a     <= {32'd0, w_abs1};
            r_b     <= w_abs2;
            // Quotient/product sign; remainder follows the dividend.
            r_neg_q <= w_signed && (Rdata1[31] ^ Rdata2[31]);
            r_neg_r <= w_signed && Rdata1[31];
            r_dz    <= (Rdata2 == 32'd0);
            r_dvd   <= Rdata1;
          end else if (w_go && w_rform && Func == F_MTHI) begin
            r_hi <= Rdata1;
          end else if (w_go && w_rform && Func == F_MTLO) begin
            r_lo <= Rdata1;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_div) begin
            r_acc <= w_div_acc;
          end else begin
            r_acc <= w_mul_acc;
            r_a   <= {r_a[62:0], 1'b0};
            r_b   <= {1'b0, r_b[31:1]};
          end
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!r_div) begin
            {r_hi, r_lo} <= r_neg_q ? (64'd0 - r_acc) : r_acc;
          end else if (r_dz) begin
            r_hi <= r_dvd;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_lo <= r_neg_q ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
            r_hi <= r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    HiLoData = 32'd0;
    if (w_go && w_rform && Func == F_MFHI) HiLoData = r_hi;
    else if (w_go && w_rform && Func == F_MFLO) HiLoData = r_lo;
  end

  assign Hi = r_hi;
  assign Lo = r_lo;

endmodule
